// File: rtl/secuenciador_instrucciones_pkg.sv
// Shared definitions for the instruction sequencer: datapath field layout,
// MC encodings, the NOP word and the sequencer FSM states.
package secuenciador_instrucciones_pkg;

    localparam int ANCHO_INSTR_P = 20;
    localparam int PROF_P        = 64;
    localparam int ANCHO_DIR_P   = 6;

    // Field bit positions of the datapath instruction word
    localparam int MC_MSB   = 19;
    localparam int MC_LSB   = 18;
    localparam int OP1_MSB  = 17;
    localparam int OP1_LSB  = 13;
    localparam int ALUC_MSB = 12;
    localparam int ALUC_LSB = 10;
    localparam int OP2_MSB  = 9;
    localparam int OP2_LSB  = 5;
    localparam int MB_MSB   = 4;
    localparam int MB_LSB   = 0;

    // MC field encodings
    localparam logic [1:0] MC_NOP       = 2'b00;
    localparam logic [1:0] MC_ESCRIBE_A = 2'b01;
    localparam logic [1:0] MC_ESCRIBE_B = 2'b10;

    // All-zero word: MC=00, so the datapath writes nothing
    localparam logic [ANCHO_INSTR_P-1:0] INSTR_NOP = '0;

    typedef enum logic [1:0] {
        REPOSO  = 2'd0,
        EJECUTA = 2'd1,
        TERMINA = 2'd2
    } estado_t;

endpackage

// File: rtl/secuenciador_instrucciones_memoria_programa.sv
// Program memory: synchronous write, combinational read. Contents are not
// affected by reset.
module memoria_programa
    import secuenciador_instrucciones_pkg::*;
#(
    parameter int ANCHO_INSTR = ANCHO_INSTR_P,
    parameter int PROF        = PROF_P,
    parameter int ANCHO_DIR   = ANCHO_DIR_P
) (
    input  logic                   clk,
    input  logic                   we,
    input  logic [ANCHO_DIR-1:0]   dir_esc,
    input  logic [ANCHO_INSTR-1:0] dato_esc,
    input  logic [ANCHO_DIR-1:0]   dir_lec,
    output logic [ANCHO_INSTR-1:0] dato_lec
);

    logic [ANCHO_INSTR-1:0] mem [PROF];

    // Word write on the rising edge when enabled
    always_ff @(posedge clk) begin
        if (we) begin
            mem[dir_esc] <= dato_esc;
        end
    end

    assign dato_lec = mem[dir_lec];

endmodule

// File: rtl/secuenciador_instrucciones.sv
// Instruction sequencer feeding the Chocorrol datapath. Loads a program while
// idle, then issues the latched number of words one per clock from address 0,
// emitting NOPs whenever no real word is on the bus.
module secuenciador_instrucciones
    import secuenciador_instrucciones_pkg::*;
#(
    parameter int ANCHO_INSTR = ANCHO_INSTR_P,
    parameter int PROF        = PROF_P,
    parameter int ANCHO_DIR   = ANCHO_DIR_P
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   carga_we,
    input  logic [ANCHO_DIR-1:0]   carga_dir,
    input  logic [ANCHO_INSTR-1:0] carga_dato,
    input  logic                   inicio,
    input  logic [ANCHO_DIR:0]     longitud,
    input  logic                   paro,
    output logic [ANCHO_INSTR-1:0] instruccion,
    output logic                   valido,
    output logic [ANCHO_DIR-1:0]   pc,
    output logic                   ocupado,
    output logic                   fin
);

    localparam logic [ANCHO_DIR:0] PROF_L = (ANCHO_DIR+1)'(PROF);
    localparam logic [ANCHO_DIR:0] UNO_L  = (ANCHO_DIR+1)'(1);

    estado_t                estado_reg, estado_next;
    logic [ANCHO_DIR-1:0]   pc_reg, pc_next;
    logic [ANCHO_DIR:0]     longitud_reg, longitud_next;
    logic [ANCHO_INSTR-1:0] instr_reg, instr_next;
    logic                   valido_reg, valido_next;
    logic                   fin_reg, fin_next;

    logic                   mem_we;
    logic [ANCHO_INSTR-1:0] dato_mem;
    logic [ANCHO_DIR:0]     longitud_limitada;
    logic                   ultima;

    // Loads are only honoured while idle so a running program is never altered
    assign mem_we = carga_we && (estado_reg == REPOSO);

    memoria_programa #(
        .ANCHO_INSTR (ANCHO_INSTR),
        .PROF        (PROF),
        .ANCHO_DIR   (ANCHO_DIR)
    ) u_memoria (
        .clk      (clk),
        .we       (mem_we),
        .dir_esc  (carga_dir),
        .dato_esc (carga_dato),
        .dir_lec  (pc_reg),
        .dato_lec (dato_mem)
    );

    // Out-of-range lengths are clamped to the full memory depth
    assign longitud_limitada = (longitud > PROF_L) ? PROF_L : longitud;

    // The word at PC is the last one of the program
    assign ultima = ({1'b0, pc_reg} == (longitud_reg - UNO_L));

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_reg   <= REPOSO;
            pc_reg       <= '0;
            longitud_reg <= '0;
            instr_reg    <= INSTR_NOP;
            valido_reg   <= 1'b0;
            fin_reg      <= 1'b0;
        end else begin
            estado_reg   <= estado_next;
            pc_reg       <= pc_next;
            longitud_reg <= longitud_next;
            instr_reg    <= instr_next;
            valido_reg   <= valido_next;
            fin_reg      <= fin_next;
        end
    end

    // Next-state and next-output logic; the bus defaults to NOP every cycle
    always_comb begin
        estado_next   = estado_reg;
        pc_next       = pc_reg;
        longitud_next = longitud_reg;
        instr_next    = INSTR_NOP;
        valido_next   = 1'b0;
        fin_next      = 1'b0;
        case (estado_reg)
            REPOSO: begin
                if (inicio) begin
                    longitud_next = longitud_limitada;
                    pc_next       = '0;
                    estado_next   = (longitud_limitada == '0) ? TERMINA : EJECUTA;
                end
            end
            EJECUTA: begin
                // A stall issues a NOP and holds PC, so the same word goes next
                if (!paro) begin
                    instr_next  = dato_mem;
                    valido_next = 1'b1;
                    pc_next     = pc_reg + 1'b1;
                    if (ultima) begin
                        estado_next = TERMINA;
                    end
                end
            end
            TERMINA: begin
                fin_next    = 1'b1;
                estado_next = REPOSO;
            end
            default: begin
                estado_next = REPOSO;
            end
        endcase
    end

    assign instruccion = instr_reg;
    assign valido      = valido_reg;
    assign pc          = pc_reg;
    assign ocupado     = (estado_reg != REPOSO);
    assign fin         = fin_reg;

endmodule

// File: tb/tb_secuenciador_instrucciones.sv
// Directed bench for the instruction sequencer: reset, normal run, stall,
// zero length, ignored inputs, load+start in one cycle, full depth and clamp.
module tb_secuenciador_instrucciones;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        carga_we;
    logic [5:0]  carga_dir;
    logic [19:0] carga_dato;
    logic        inicio;
    logic [6:0]  longitud;
    logic        paro;
    logic [19:0] instruccion;
    logic        valido;
    logic [5:0]  pc;
    logic        ocupado;
    logic        fin;

    int checks = 0;
    int errors = 0;

    secuenciador_instrucciones dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .carga_we    (carga_we),
        .carga_dir   (carga_dir),
        .carga_dato  (carga_dato),
        .inicio      (inicio),
        .longitud    (longitud),
        .paro        (paro),
        .instruccion (instruccion),
        .valido      (valido),
        .pc          (pc),
        .ocupado     (ocupado),
        .fin         (fin)
    );

    always #5 clk = ~clk;

    // Advance one edge and settle away from it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic carga(input logic [5:0] d, input logic [19:0] v);
        carga_we   = 1'b1;
        carga_dir  = d;
        carga_dato = v;
        step();
        carga_we   = 1'b0;
    endtask

    task automatic arranca(input logic [6:0] l);
        inicio   = 1'b1;
        longitud = l;
        step();
        inicio   = 1'b0;
    endtask

    task automatic test_reset();
        $display("test_reset");
        checks++;
        if ({instruccion, valido, pc, ocupado, fin} !== 29'd0) begin
            errors++;
            $display("FAIL reset_values got instr=%h v=%b pc=%0d oc=%b fin=%b want all 0",
                     instruccion, valido, pc, ocupado, fin);
        end
        rst_n = 1'b1;
        carga(6'd0, 20'h40001);
        carga(6'd1, 20'h40402);
        carga(6'd2, 20'h80801);
        carga(6'd3, 20'h00000);
        arranca(7'd4);
        step();
        checks++;
        if (instruccion !== 20'h40001) begin
            errors++;
            $display("FAIL reset_run_w0 got %h want 40001", instruccion);
        end
        step();
        checks++;
        if (instruccion !== 20'h40402) begin
            errors++;
            $display("FAIL reset_run_w1 got %h want 40402", instruccion);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({instruccion, valido, pc, ocupado} !== 28'd0) begin
            errors++;
            $display("FAIL reset_async got instr=%h v=%b pc=%0d oc=%b want 0",
                     instruccion, valido, pc, ocupado);
        end
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (fin !== 1'b0) begin
                errors++;
                $display("FAIL reset_no_fin cycle %0d got %b want 0", k, fin);
            end
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_normal();
        logic [19:0] esp [3];
        esp[0] = 20'h40001;
        esp[1] = 20'h40402;
        esp[2] = 20'h80801;
        $display("test_normal");
        arranca(7'd3);
        checks++;
        if ({valido, ocupado, pc} !== {1'b0, 1'b1, 6'd0}) begin
            errors++;
            $display("FAIL normal_start got v=%b oc=%b pc=%0d want 0 1 0", valido, ocupado, pc);
        end
        for (int k = 0; k < 3; k++) begin
            step();
            $display("  word %0d instr=%h pc=%0d", k, instruccion, pc);
            checks++;
            if ({instruccion, valido, pc} !== {esp[k], 1'b1, 6'(k + 1)}) begin
                errors++;
                $display("FAIL normal_word%0d got %h v=%b pc=%0d want %h 1 %0d",
                         k, instruccion, valido, pc, esp[k], k + 1);
            end
        end
        checks++;
        if ({ocupado, fin} !== 2'b10) begin
            errors++;
            $display("FAIL normal_termina got oc=%b fin=%b want 1 0", ocupado, fin);
        end
        step();
        checks++;
        if ({instruccion, valido, fin, ocupado} !== {20'h0, 1'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL normal_fin got instr=%h v=%b fin=%b oc=%b want 0 0 1 0",
                     instruccion, valido, fin, ocupado);
        end
        step();
        checks++;
        if (fin !== 1'b0) begin
            errors++;
            $display("FAIL normal_fin_pulse got %b want 0", fin);
        end
    endtask

    task automatic test_stall();
        $display("test_stall");
        arranca(7'd3);
        step();
        checks++;
        if ({instruccion, pc} !== {20'h40001, 6'd1}) begin
            errors++;
            $display("FAIL stall_w0 got %h pc=%0d want 40001 1", instruccion, pc);
        end
        paro = 1'b1;
        for (int k = 0; k < 2; k++) begin
            step();
            checks++;
            if ({instruccion, valido, pc} !== {20'h0, 1'b0, 6'd1}) begin
                errors++;
                $display("FAIL stall_nop%0d got %h v=%b pc=%0d want 0 0 1",
                         k, instruccion, valido, pc);
            end
        end
        paro = 1'b0;
        step();
        checks++;
        if ({instruccion, valido, pc} !== {20'h40402, 1'b1, 6'd2}) begin
            errors++;
            $display("FAIL stall_w1 got %h v=%b pc=%0d want 40402 1 2", instruccion, valido, pc);
        end
        step();
        checks++;
        if ({instruccion, valido, pc} !== {20'h80801, 1'b1, 6'd3}) begin
            errors++;
            $display("FAIL stall_w2 got %h v=%b pc=%0d want 80801 1 3", instruccion, valido, pc);
        end
        step();
        checks++;
        if ({valido, fin} !== 2'b01) begin
            errors++;
            $display("FAIL stall_fin got v=%b fin=%b want 0 1", valido, fin);
        end
        step();
    endtask

    task automatic test_zero();
        $display("test_zero");
        arranca(7'd0);
        checks++;
        if ({ocupado, valido, fin} !== 3'b100) begin
            errors++;
            $display("FAIL zero_termina got oc=%b v=%b fin=%b want 1 0 0", ocupado, valido, fin);
        end
        step();
        checks++;
        if ({ocupado, valido, fin} !== 3'b001) begin
            errors++;
            $display("FAIL zero_fin got oc=%b v=%b fin=%b want 0 0 1", ocupado, valido, fin);
        end
        step();
    endtask

    task automatic test_ignored();
        $display("test_ignored");
        arranca(7'd3);
        step();
        carga_we   = 1'b1;
        carga_dir  = 6'd1;
        carga_dato = 20'hFFFFF;
        inicio     = 1'b1;
        longitud   = 7'd2;
        step();
        carga_we = 1'b0;
        inicio   = 1'b0;
        checks++;
        if ({instruccion, pc} !== {20'h40402, 6'd2}) begin
            errors++;
            $display("FAIL ignored_w1 got %h pc=%0d want 40402 2", instruccion, pc);
        end
        step();
        checks++;
        if (instruccion !== 20'h80801) begin
            errors++;
            $display("FAIL ignored_w2 got %h want 80801", instruccion);
        end
        step();
        checks++;
        if (fin !== 1'b1) begin
            errors++;
            $display("FAIL ignored_fin got %b want 1", fin);
        end
        arranca(7'd2);
        step();
        step();
        checks++;
        if ({instruccion, valido} !== {20'h40402, 1'b1}) begin
            errors++;
            $display("FAIL ignored_mem1 got %h v=%b want 40402 1", instruccion, valido);
        end
        step();
        step();
    endtask

    task automatic test_back_to_back();
        $display("test_back_to_back");
        carga_we   = 1'b1;
        carga_dir  = 6'd0;
        carga_dato = 20'h12345;
        inicio     = 1'b1;
        longitud   = 7'd1;
        step();
        carga_we = 1'b0;
        inicio   = 1'b0;
        step();
        checks++;
        if ({instruccion, valido, pc} !== {20'h12345, 1'b1, 6'd1}) begin
            errors++;
            $display("FAIL b2b_word got %h v=%b pc=%0d want 12345 1 1", instruccion, valido, pc);
        end
        step();
        checks++;
        if ({valido, fin} !== 2'b01) begin
            errors++;
            $display("FAIL b2b_fin got v=%b fin=%b want 0 1", valido, fin);
        end
        step();
    endtask

    task automatic test_full();
        int fins;
        int validos;
        $display("test_full");
        for (int i = 0; i < 64; i++) begin
            carga(6'(i), 20'(i));
        end
        arranca(7'd64);
        for (int i = 0; i < 64; i++) begin
            step();
            checks++;
            if ({instruccion, valido} !== {20'(i), 1'b1}) begin
                errors++;
                $display("FAIL full_word%0d got %h v=%b want %h 1", i, instruccion, valido, 20'(i));
            end
        end
        checks++;
        if (pc !== 6'd0) begin
            errors++;
            $display("FAIL full_pc_wrap got %0d want 0", pc);
        end
        fins = 0;
        for (int k = 0; k < 4; k++) begin
            step();
            if (fin === 1'b1) fins++;
        end
        checks++;
        if (fins != 1) begin
            errors++;
            $display("FAIL full_fin_count got %0d want 1", fins);
        end
        // Out-of-range length behaves as the full depth
        arranca(7'd100);
        fins = 0;
        validos = 0;
        for (int k = 0; k < 70; k++) begin
            step();
            if (valido === 1'b1) validos++;
            if (fin === 1'b1) fins++;
        end
        $display("  clamp run valid=%0d fin=%0d", validos, fins);
        checks++;
        if (validos != 64) begin
            errors++;
            $display("FAIL clamp_valid_count got %0d want 64", validos);
        end
        checks++;
        if (fins != 1) begin
            errors++;
            $display("FAIL clamp_fin_count got %0d want 1", fins);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        carga_we   = 1'b0;
        carga_dir  = '0;
        carga_dato = '0;
        inicio     = 1'b0;
        longitud   = '0;
        paro       = 1'b0;
        repeat (2) step();
        test_reset();
        test_normal();
        test_stall();
        test_zero();
        test_ignored();
        test_back_to_back();
        test_full();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
